// File: rtl/ofm_wr_merge_pkg.sv
// Shared constants and helpers for the feature-map write merge.
// Each FIFO entry is packed as {data, addr, src}, with src in the low bits.
package ofm_wr_merge_pkg;

    localparam int OFM_AW = 14;
    localparam int OFM_DW = 48;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // The source index field is never narrower than one bit.
    function automatic int src_w(input int nch);
        return (nch <= 1) ? 1 : clog2(nch);
    endfunction

    function automatic int ent_w(input int dw, input int aw, input int sw);
        return dw + aw + sw;
    endfunction

    function automatic int src_lsb();
        return 0;
    endfunction

    function automatic int addr_lsb(input int sw);
        return sw;
    endfunction

    function automatic int data_lsb(input int aw, input int sw);
        return sw + aw;
    endfunction

endpackage

// File: rtl/ofm_wr_merge_rr_arb.sv
// NCH-wide round-robin arbiter. The scan starts at ptr and wraps.
// ptr moves to one past the winner only when advance is high.
module ofm_wr_merge_rr_arb
    import ofm_wr_merge_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] ptr;

    always_comb begin
        int unsigned c;
        c     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            c = 32'(ptr) + k;
            if (c >= N) c = c - N;
            if (!any && req[c]) begin
                any      = 1'b1;
                grant[c] = 1'b1;
                idx      = IW'(c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
        end
    end

endmodule

// File: rtl/ofm_wr_merge.sv
// Merges NCH write streams into a DEPTH-entry FIFO feeding the feature-map RAM.
// Build option OFM_WR_MERGE_ADDR_CHK_EN drops writes above ADDR_MAX and sets a sticky addr_err.
module ofm_wr_merge
    import ofm_wr_merge_pkg::*;
#(
    parameter int unsigned     NCH      = 2,
    parameter int unsigned     DW       = OFM_DW,
    parameter int unsigned     AW       = OFM_AW,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [AW-1:0]   ADDR_MAX = AW'(14'h3FFF)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NCH*DW-1:0]             s_data,
    input  logic [NCH*AW-1:0]             s_addr,
    input  logic [NCH-1:0]                s_valid,
    output logic [NCH-1:0]                s_ready,
    output logic [DW-1:0]                 m_data,
    output logic [AW-1:0]                 m_addr,
    output logic [src_w(NCH)-1:0]         m_src,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [clog2(DEPTH+1)-1:0]     level,
    output logic                          addr_err
);

    localparam int unsigned SRC_W    = src_w(NCH);
    localparam int unsigned PW       = clog2(DEPTH);
    localparam int unsigned LW       = clog2(DEPTH + 1);
    localparam int unsigned ENT_W    = ent_w(DW, AW, SRC_W);
    localparam int unsigned SRC_LSB  = src_lsb();
    localparam int unsigned ADDR_LSB = addr_lsb(SRC_W);
    localparam int unsigned DATA_LSB = data_lsb(AW, SRC_W);

    logic [NCH-1:0]   gnt;
    logic [SRC_W-1:0] gnt_idx;
    logic             gnt_any;
    logic [DW-1:0]    sel_data;
    logic [AW-1:0]    sel_addr;
    logic             space, pop, hs, push, bad_addr;
    logic [ENT_W-1:0] mem [DEPTH];
    logic [ENT_W-1:0] head;
    logic [PW-1:0]    wr_ptr, rd_ptr;

    ofm_wr_merge_rr_arb #(
        .N  (NCH),
        .IW (SRC_W)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (s_valid),
        .advance (hs),
        .grant   (gnt),
        .idx     (gnt_idx),
        .any     (gnt_any)
    );

    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign pop     = m_valid && m_ready;
    assign space   = (level < LW'(DEPTH)) || pop;
    assign s_ready = space ? gnt : '0;
    assign hs      = space && gnt_any;

    always_comb begin
        sel_data = '0;
        sel_addr = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (gnt[i]) begin
                sel_data = sel_data | s_data[i*DW +: DW];
                sel_addr = sel_addr | s_addr[i*AW +: AW];
            end
        end
    end

`ifdef OFM_WR_MERGE_ADDR_CHK_EN
    // Out-of-range writes still complete the handshake so the source is not stalled.
    assign bad_addr = (sel_addr > ADDR_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_err <= 1'b0;
        end else if (hs && bad_addr) begin
            addr_err <= 1'b1;
        end
    end
`else
    logic unused_addr_max;
    assign unused_addr_max = ^ADDR_MAX;
    assign bad_addr        = 1'b0;
    assign addr_err        = 1'b0;
`endif

    assign push = hs && !bad_addr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {sel_data, sel_addr, gnt_idx};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    assign head    = mem[rd_ptr];
    assign m_data  = head[DATA_LSB +: DW];
    assign m_addr  = head[ADDR_LSB +: AW];
    assign m_src   = head[SRC_LSB +: SRC_W];
    assign m_valid = (level != '0);

endmodule

// File: tb/tb_ofm_wr_merge.sv
// Directed and random checks of ofm_wr_merge against a queue-based reference model.
// Two instances: NCH=2/DEPTH=4 for directed steps, NCH=1/DEPTH=2 for a random run.
module tb_ofm_wr_merge;

    localparam int NCH   = 2;
    localparam int DW    = 48;
    localparam int AW    = 14;
    localparam int DEPTH = 4;
    localparam logic [AW-1:0] AMAX = 14'h0FFF;
`ifdef OFM_WR_MERGE_ADDR_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct packed {
        logic [0:0]    src;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NCH*DW-1:0] s_data;
    logic [NCH*AW-1:0] s_addr;
    logic [NCH-1:0]    s_valid, s_ready;
    logic [DW-1:0]     m_data;
    logic [AW-1:0]     m_addr;
    logic [0:0]        m_src;
    logic              m_valid, m_ready;
    logic [2:0]        level;
    logic              addr_err;

    logic [DW-1:0] d1_s_data, d1_m_data;
    logic [AW-1:0] d1_s_addr, d1_m_addr;
    logic [0:0]    d1_s_valid, d1_s_ready, d1_m_src;
    logic          d1_m_valid, d1_m_ready, d1_addr_err;
    logic [1:0]    d1_level;

    ofm_wr_merge #(
        .NCH(NCH), .DW(DW), .AW(AW), .DEPTH(DEPTH), .ADDR_MAX(AMAX)
    ) u_dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_addr(s_addr), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_addr(m_addr), .m_src(m_src), .m_valid(m_valid),
        .m_ready(m_ready), .level(level), .addr_err(addr_err)
    );

    ofm_wr_merge #(
        .NCH(1), .DW(DW), .AW(AW), .DEPTH(2), .ADDR_MAX(AMAX)
    ) u_dut1 (
        .clk(clk), .rst(rst),
        .s_data(d1_s_data), .s_addr(d1_s_addr), .s_valid(d1_s_valid), .s_ready(d1_s_ready),
        .m_data(d1_m_data), .m_addr(d1_m_addr), .m_src(d1_m_src), .m_valid(d1_m_valid),
        .m_ready(d1_m_ready), .level(d1_level), .addr_err(d1_addr_err)
    );

    ent_t        q0[$];
    ent_t        q1[$];
    logic [0:0]  pop_src[$];
    int unsigned mptr, mlev, mlev1;
    bit          merr;
    int          checks = 0;
    int          errors = 0;
    int          hs_ch;
    int          hs_cnt;
    int unsigned a0, a1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check both DUTs against the model at the falling edge, then advance the model.
    task automatic step();
        bit           mpop, mspace, found, bad, p1, sp1;
        int unsigned  g, c;
        logic [NCH-1:0] exp_rdy;
        ent_t         e, e1;
        @(negedge clk);
        mpop   = (mlev != 0) && m_ready;
        mspace = (mlev < DEPTH) || mpop;
        found  = 1'b0;
        g      = 0;
        for (int k = 0; k < NCH; k++) begin
            c = (mptr + k) % NCH;
            if (!found && s_valid[c]) begin
                found = 1'b1;
                g     = c;
            end
        end
        exp_rdy = '0;
        if (found && mspace) exp_rdy[g] = 1'b1;
        chk("s_ready", 128'(s_ready), 128'(exp_rdy));
        chk("m_valid", 128'(m_valid), 128'(mlev != 0));
        chk("level", 128'(level), 128'(mlev));
        chk("addr_err", 128'(addr_err), 128'(merr));
        if (mlev != 0 && q0.size() != 0) chk("head", 128'({m_src, m_addr, m_data}), 128'(q0[0]));
        if ((s_valid & s_ready) != '0) hs_cnt++;
        if (mpop && m_valid) pop_src.push_back(m_src);
        e.src  = 1'(g);
        e.addr = s_addr[g*AW +: AW];
        e.data = s_data[g*DW +: DW];
        bad    = CHK && (e.addr > AMAX);

        p1  = (mlev1 != 0) && d1_m_ready;
        sp1 = (mlev1 < 2) || p1;
        chk("d1_s_ready", 128'(d1_s_ready), 128'(d1_s_valid && sp1));
        chk("d1_m_valid", 128'(d1_m_valid), 128'(mlev1 != 0));
        chk("d1_level", 128'(d1_level), 128'(mlev1));
        chk("d1_addr_err", 128'(d1_addr_err), 128'(0));
        if (mlev1 != 0 && q1.size() != 0)
            chk("d1_head", 128'({d1_m_src, d1_m_addr, d1_m_data}), 128'(q1[0]));
        e1.src  = 1'b0;
        e1.addr = d1_s_addr;
        e1.data = d1_s_data;

        @(posedge clk);
        hs_ch = -1;
        if (rst) begin
            q0.delete();
            q1.delete();
            mlev  = 0;
            mlev1 = 0;
            mptr  = 0;
            merr  = 1'b0;
        end else begin
            if (mpop) begin
                void'(q0.pop_front());
                mlev--;
            end
            if (found && mspace) begin
                hs_ch = int'(g);
                mptr  = (g + 1) % NCH;
                if (bad) merr = 1'b1;
                else begin
                    q0.push_back(e);
                    mlev++;
                end
            end
            if (p1) begin
                void'(q1.pop_front());
                mlev1--;
            end
            if (d1_s_valid && sp1) begin
                q1.push_back(e1);
                mlev1++;
            end
        end
        #1;
    endtask

    task automatic drive_ch(input int ch, input int unsigned addr);
        s_addr[ch*AW +: AW] = AW'(addr);
        s_data[ch*DW +: DW] = DW'({ch[3:0], 12'hC0D, addr[15:0]});
    endtask

    initial begin
        rst = 1'b1;
        s_valid = '0; s_data = '0; s_addr = '0; m_ready = 1'b0;
        d1_s_valid = '0; d1_s_data = '0; d1_s_addr = '0; d1_m_ready = 1'b0;
        mptr = 0; mlev = 0; mlev1 = 0; merr = 1'b0; hs_ch = -1; hs_cnt = 0;
        @(posedge clk);
        #1;
        step();
        rst = 1'b0;
        chk("rst_s_ready", 128'(s_ready), 128'(0));
        chk("rst_m_valid", 128'(m_valid), 128'(0));
        chk("rst_level", 128'(level), 128'(0));
        chk("rst_addr_err", 128'(addr_err), 128'(0));

        // Single push from ch0
        s_valid = 2'b01;
        s_addr[0 +: AW] = 14'h010;
        s_data[0 +: DW] = 48'hA5;
        m_ready = 1'b1;
        step();
        s_valid = '0;
        chk("sp_m_valid", 128'(m_valid), 128'(1));
        chk("sp_m_addr", 128'(m_addr), 128'(14'h010));
        chk("sp_m_data", 128'(m_data), 128'(48'hA5));
        chk("sp_m_src", 128'(m_src), 128'(0));
        chk("sp_level1", 128'(level), 128'(1));
        step();
        chk("sp_level0", 128'(level), 128'(0));

        // Round robin with both channels always valid
        rst = 1'b1;
        step();
        rst = 1'b0;
        a0 = 'h100; a1 = 'h200;
        s_valid = 2'b11;
        pop_src.delete();
        for (int i = 0; i < 6; i++) begin
            drive_ch(0, a0);
            drive_ch(1, a1);
            step();
            if (hs_ch == 0) a0++;
            if (hs_ch == 1) a1++;
        end
        s_valid = '0;
        repeat (2) step();
        chk("rr_pops", 128'(pop_src.size()), 128'(6));
        for (int i = 0; i < 6; i++) begin
            if (i < pop_src.size()) chk("rr_src", 128'(pop_src[i]), 128'(i % 2));
        end

        // Fill and backpressure from ch1
        m_ready = 1'b0;
        s_valid = 2'b10;
        hs_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            drive_ch(1, a1);
            step();
            if (hs_ch == 1) a1++;
        end
        chk("bp_accepted", 128'(hs_cnt), 128'(4));
        chk("bp_level", 128'(level), 128'(4));
        chk("bp_ready", 128'(s_ready), 128'(0));
        m_ready = 1'b1;
        drive_ch(1, a1);
        step();
        if (hs_ch == 1) a1++;
        m_ready = 1'b0;
        chk("bp_level_hold", 128'(level), 128'(4));
        chk("bp_fifth", 128'(hs_cnt), 128'(5));
        s_valid = '0;
        m_ready = 1'b1;
        repeat (5) step();
        chk("bp_drained", 128'(level), 128'(0));

        // Reset with three entries queued
        m_ready = 1'b0;
        s_valid = 2'b01;
        for (int i = 0; i < 3; i++) begin
            drive_ch(0, a0);
            step();
            if (hs_ch == 0) a0++;
        end
        s_valid = '0;
        chk("rm_level3", 128'(level), 128'(3));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rm_m_valid", 128'(m_valid), 128'(0));
        chk("rm_level", 128'(level), 128'(0));
        s_valid = 2'b11;
        drive_ch(0, a0);
        drive_ch(1, a1);
        #1;
        chk("rm_ptr", 128'(s_ready), 128'(2'b01));
        step();
        s_valid = '0;
        m_ready = 1'b1;
        repeat (3) step();

        // Address range handling
        s_valid = 2'b01;
        drive_ch(0, 'h1000);
        step();
        s_valid = '0;
        chk("ac_m_valid", 128'(m_valid), 128'(!CHK));
        chk("ac_level", 128'(level), 128'(!CHK));
        chk("ac_err", 128'(addr_err), 128'(CHK));
        step();
        s_valid = 2'b01;
        drive_ch(0, 'h0FFF);
        step();
        s_valid = '0;
        chk("ac_pass_valid", 128'(m_valid), 128'(1));
        chk("ac_pass_addr", 128'(m_addr), 128'(14'h0FFF));
        repeat (3) step();
        chk("ac_err_sticky", 128'(addr_err), 128'(CHK));

        // Random traffic on the single-channel, two-entry instance
        for (int i = 0; i < 1000; i++) begin
            d1_s_valid = 1'($urandom_range(0, 1));
            d1_m_ready = 1'($urandom_range(0, 1));
            d1_s_addr  = AW'($urandom_range(0, 'h0FFF));
            d1_s_data  = DW'({$urandom(), $urandom()});
            step();
        end
        d1_s_valid = '0;
        d1_m_ready = 1'b1;
        repeat (3) step();
        chk("d1_drained", 128'(d1_level), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ofm_wr_merge.md
Name: ofm_wr_merge

Overview:
- Parametrised successor to the single-stage {data,addr} write register slice that feeds the feature-map RAM write port.
- Merges NCH independent write streams (each carries data and a word address) into one write stream. Example sources: CWDMA output-fm writes and picture preload writes.
- Arbitration is round-robin. Accepted writes are buffered in a DEPTH-entry FIFO.
- Reports the source channel, the FIFO level and an optional address-range error.

Parameters:
- NCH, 2, number of write source channels (1..8)
- DW, 48, write data width
- AW, 14, write address width
- DEPTH, 4, FIFO entries, power of two, ≥2
- ADDR_MAX, 14'h3FFF, highest legal write address (used only with the optional feature)

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-high
- s_data  in  NCH*DW  per-channel write data; channel i occupies bits [i*DW +: DW]
- s_addr  in  NCH*AW  per-channel write address; channel i occupies bits [i*AW +: AW]
- s_valid  in  NCH  per-channel valid
- s_ready  out  NCH  per-channel ready
- m_data  out  DW  merged write data
- m_addr  out  AW  merged write address
- m_src  out  clog2(NCH) (min 1)  channel index of the current head entry
- m_valid  out  1  head entry valid
- m_ready  in  1  sink accepts the head entry
- level  out  clog2(DEPTH+1)  current FIFO occupancy
- addr_err  out  1  sticky out-of-range flag; tied 0 when the optional feature is compiled out

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values: s_ready=0, m_valid=0, level=0, addr_err=0, RR pointer=0. m_data, m_addr and m_src are don't-care while m_valid=0.
- Space: space = (level<DEPTH) || (m_valid && m_ready). A full FIFO accepts a push in the same cycle as a pop.
- Arbiter, combinational:
  - grant = first channel i with s_valid[i]=1, scanning from ptr upward with wrap.
  - s_ready[i] = space && grant==i. Exactly one s_ready is high at most.
  - s_ready may depend on s_valid, as allowed by the valid/ready rule. s_valid must not depend on s_ready.
- Push: when s_valid[g] && s_ready[g], write {data,addr,g} to the tail and set ptr = (g+1) mod NCH. With no push, ptr holds.
- Pop: when m_valid && m_ready, advance the head.
- Head outputs: m_valid = (level!=0). Head outputs come from registered storage, with no combinational input-to-output path.
- Latency: a write accepted in cycle t is visible on m_* in cycle t+1 at the earliest.
- Throughput: one write per cycle sustained when m_ready=1.
- level: +1 on push only, −1 on pop only, unchanged on both or neither. Never exceeds DEPTH and never underflows.
- Read/write pointers: clog2(DEPTH) bits, wrapping naturally.
- Ordering:
  - Each channel's writes leave in their acceptance order.
  - Across channels, output order equals grant order.
- Fairness: when every channel holds valid continuously, grants rotate 0,1,…,NCH−1,0…
- Backpressure: m_ready=0 with the FIFO full makes all s_ready=0, and ptr holds.
- Reset mid-operation: FIFO contents are discarded, level=0 and ptr=0 on the next edge. Upstream must re-present any write not yet handshaken.
- NCH=1: arbiter degenerates to s_ready[0]=space, and m_src=0.

Optional Feature:
- Macro: OFM_WR_MERGE_ADDR_CHK_EN.
- Defined:
  - A granted write with addr>ADDR_MAX is still handshaken (s_ready high) but is not pushed. level is unchanged and ptr still advances.
  - addr_err is set on the next edge and stays set until rst.
- Undefined:
  - All granted writes are pushed regardless of address.
  - addr_err is constant 0, and ADDR_MAX is ignored.

Decomposition:
- Shared package:
  - clog2 function.
  - OFM_AW=14 and OFM_DW=48 constants.
  - Entry layout localparam ENT_W = DW+AW+SRC_W, with field offsets for data/addr/src.
- Sub-module: rr_arb (NCH-wide round-robin arbiter; inputs req and advance, outputs one-hot grant and index). It holds ptr and is reused for future read-side arbitration.
- FIFO storage stays inline.

Test Plan:
- Single push, NCH=2: ch0 sends addr=0x010, data=0xA5 with m_ready=1. Required: s_ready[0]=1 at t; m_valid=1, m_addr=0x010, m_src=0 at t+1; level=1 then 0.
- Round-robin: both channels hold valid for 6 cycles with m_ready=1. Required: m_src sequence 0,1,0,1,0,1, and each channel's addresses stay in order.
- Full and backpressure, DEPTH=4: m_ready=0, ch1 streams 6 writes. Required: 4 accepted, level=4, s_ready=0. Then m_ready=1 for one cycle with push and pop together: level stays 4 and the 5th write is accepted.
- Reset mid-stream: rst=1 for 1 cycle with level=3. Required: next cycle m_valid=0, level=0, ptr=0 (ch0 granted first when both are valid).
- OFM_WR_MERGE_ADDR_CHK_EN, ADDR_MAX=0x0FFF: ch0 sends addr=0x1000. Required: s_ready=1, no m_valid, level=0, addr_err=1 and sticky. A following addr=0x0FFF is passed through.
- NCH=1, DEPTH=2, random valid/ready for 1000 cycles: output sequence matches a reference queue and level matches the model every cycle.
